// File: rtl/coreport_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coreport_pkg: coreport register map and sequencer state encoding     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package coreport_pkg;

    localparam logic [31:0] REG_DATAR = 32'h00;
    localparam logic [31:0] REG_DDR   = 32'h04;
    localparam logic [31:0] REG_IMR   = 32'h08;
    localparam logic [31:0] REG_IFR   = 32'h0C;
    localparam logic [31:0] REG_IER   = 32'h10;
    localparam logic [31:0] REG_DIR   = 32'h14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DELAY = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/coreport_seq_tbl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coreport_seq_tbl: (value, delay) pattern table, sync write/async read|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coreport_seq_tbl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [WIDTH-1:0]   wvalue_i,
    input  logic [DELAY_W-1:0] wdelay_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [WIDTH-1:0]   rvalue_o,
    output logic [DELAY_W-1:0] rdelay_o
);

    logic [WIDTH+DELAY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wvalue_i, wdelay_i};
        end
    end

    assign {rvalue_o, rdelay_o} = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/coreport_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coreport_seq: Wishbone master playing a (value, delay) table to a    |
// | coreport DATAR register after configuring its DDR.   Rev 1.0         |
// +----------------------------------------------------------------------+
module coreport_seq
    import coreport_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          DEPTH       = 16,
    parameter int          DELAY_W     = 16,
    parameter logic [31:0] BASE_ADR    = 32'h0,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_addr,
    input  logic [WIDTH-1:0]         tbl_value,
    input  logic [DELAY_W-1:0]       tbl_delay,
    input  logic [$clog2(DEPTH):0]   seq_len,
    input  logic                     seq_loop,
    input  logic [WIDTH-1:0]         ddr_mask,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic [31:0]              wbm_adr_o,
    output logic [WIDTH-1:0]         wbm_dat_o,
    output logic                     wbm_we_o,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic [2:0]               wbm_cti_o,
    output logic [1:0]               wbm_bte_o,
    input  logic                     wbm_ack_i,
    input  logic                     wbm_err_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    seq_state_t         state_q;
    logic [AW-1:0]      idx_q;
    logic [LW-1:0]      len_q;
    logic               loop_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [TW-1:0]      tmo_q;
    logic               stop_pend_q;
    logic               done_q;
    logic               err_q;
    logic               cyc_q;
    logic               stb_q;
    logic               we_q;
    logic [31:0]        adr_q;
    logic [WIDTH-1:0]   dat_q;

    logic               w_last;
    logic [AW-1:0]      w_idx_nxt;
    logic [AW-1:0]      w_rd_idx;
    logic [WIDTH-1:0]   w_rd_value;
    logic [DELAY_W-1:0] w_rd_delay;
    logic               w_stop;
    logic               w_tmo;

    assign w_last    = ({1'b0, idx_q} == (len_q - LW'(1)));
    assign w_idx_nxt = w_last ? '0 : idx_q + AW'(1);
    // DELAY pre-fetches the next entry so its strobe can start on the exit edge
    assign w_rd_idx  = (state_q == ST_DELAY) ? w_idx_nxt : idx_q;
    assign w_stop    = stop | stop_pend_q;
    assign w_tmo     = (tmo_q == TW'(ACK_TIMEOUT - 1));

    coreport_seq_tbl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DELAY_W (DELAY_W)
    ) u_tbl (
        .clk      (wb_clk),
        .we_i     (tbl_we),
        .waddr_i  (tbl_addr),
        .wvalue_i (tbl_value),
        .wdelay_i (tbl_delay),
        .raddr_i  (w_rd_idx),
        .rvalue_o (w_rd_value),
        .rdelay_o (w_rd_delay)
    );

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop && (state_q != ST_IDLE)) begin
                stop_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    stop_pend_q <= 1'b0;
                    idx_q       <= '0;
                    if (start && !stop) begin
                        if (seq_len != '0) begin
                            len_q   <= seq_len;
                            loop_q  <= seq_loop;
                            err_q   <= 1'b0;
                            tmo_q   <= '0;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= BASE_ADR + REG_DDR;
                            dat_q   <= ddr_mask;
                            state_q <= ST_CFG;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_CFG, ST_WRITE: begin
                    if (stb_q) begin
                        if (wbm_err_i || (!wbm_ack_i && w_tmo)) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (wbm_ack_i) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                            if (w_stop) begin
                                state_q <= ST_IDLE;
                            end else if (state_q == ST_CFG) begin
                                idx_q   <= '0;
                                state_q <= ST_WRITE;
                            end else begin
                                cnt_q   <= w_rd_delay;
                                state_q <= ST_DELAY;
                            end
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end else if (w_stop) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // first DATAR beat after the DDR write: the bus idles one cycle
                        tmo_q <= '0;
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= BASE_ADR + REG_DATAR;
                        dat_q <= w_rd_value;
                    end
                end
                ST_DELAY: begin
                    if (w_stop) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end else if (w_last && !loop_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= w_idx_nxt;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= BASE_ADR + REG_DATAR;
                        dat_q   <= w_rd_value;
                        state_q <= ST_WRITE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign cur_idx   = ((state_q == ST_WRITE) || (state_q == ST_DELAY)) ? idx_q : '0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

endmodule
`default_nettype wire
